ble_rx_dewhiten_framer: RTL and testbench
=========================================

Name: ble_rx_dewhiten_framer

Overview:
- RX-side counterpart of the BLE TX whitening block.
- Sits after access-address correlation. On each `start` pulse it reloads the x^7+x^4+1 whitening LFSR from the channel number and de-whitens the incoming bitstream.
- Extracts the PDU length from the de-whitened header and tags each output bit as header, payload or CRC.
- Flags the last bit of the frame, so the downstream CRC checker and byte packer need no length logic.

Parameters:
- CHANNEL_NUMBER_BIT_WIDTH, 6, width of the channel number.
- LEN_BIT_WIDTH, 8, width of the PDU length field.
- MAX_PAYLOAD_LEN, 255, largest legal payload in bytes; used only with DEWHITEN_LEN_CHECK_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- channel_number  in  CHANNEL_NUMBER_BIT_WIDTH  channel; sampled when start=1
- start  in  1  one-cycle pulse at access-address match; reloads LFSR and begins a frame
- data_in  in  1  whitened bit, LSB-first air order
- data_in_valid  in  1  data_in qualifier
- data_out  out  1  de-whitened bit
- data_out_valid  out  1  data_out qualifier
- data_out_last  out  1  with data_out_valid: final CRC bit of the frame
- bit_region  out  2  region of the current data_out: 0 header, 1 payload, 2 CRC
- payload_length  out  LEN_BIT_WIDTH  de-whitened header bits 8..15; held until next start
- busy  out  1  frame in progress
- len_error  out  1  one-cycle abort pulse; tied to 0 without the feature

Behaviour:
- Reset values:
  - All outputs 0.
  - lfsr = {lfsr[0]=1, lfsr[6:1]=0}.
  - bit_cnt = 0.
  - State IDLE.
- LFSR load (start=1): lfsr[0]=1; lfsr[1..6] = channel_number[5..0] (lfsr[1]=ch[5], …, lfsr[6]=ch[0]).
- LFSR advance (each accepted bit):
  - lfsr[0]←lfsr[6]
  - lfsr[1]←lfsr[0], lfsr[2]←lfsr[1], lfsr[3]←lfsr[2]
  - lfsr[4]←lfsr[3]^lfsr[6]
  - lfsr[5]←lfsr[4], lfsr[6]←lfsr[5]
- Output: data_out = lfsr[6]^data_in, registered.
  - Latency is one cycle from an accepted bit to data_out_valid.
  - data_out_valid deasserts in any cycle with no accepted bit.
- A bit is accepted only in states HDR, PLD or CRC, with data_in_valid=1 and start=0. Bits in IDLE produce no output.
- FSM:
  - IDLE --start--> HDR; bit_cnt=0, busy=1.
  - HDR: 16 bits. De-whitened bits 8..15 shift into payload_length, LSB first. After bit 15: go to PLD if length≠0, else CRC.
  - PLD: payload_length*8 bits, then CRC. bit_cnt is 11 bits wide (max 2040).
  - CRC: 24 bits. On bit 23 assert data_out_last with that bit, then go to IDLE with busy=0.
- bit_cnt resets to 0 at every region change.
- bit_region is registered alongside data_out.
- payload_length becomes valid together with the output of header bit 15, and holds until the next start.
- start in any state, including mid-frame: LFSR reloads and the FSM goes to HDR. No data_out_last is issued for the aborted frame. A bit presented in the same cycle as start is dropped.
- rst_n low mid-frame: immediate return to the reset values, no last pulse.
- data_in_valid gaps: state and LFSR hold; no timeout.

Optional Feature:
- DEWHITEN_LEN_CHECK_EN defined:
  - After header bit 15, if payload_length > MAX_PAYLOAD_LEN: pulse len_error for one cycle aligned with that bit's data_out_valid, go to IDLE, clear busy, no data_out_last.
  - Further bits produce no output until the next start.
- Undefined: no check; len_error is constant 0.

Decomposition:
- Package ble_rx_pkg:
  - HDR_BITS=16, CRC_BITS=24, LEN_LSB_POS=8.
  - Region encodings REGION_HDR/PLD/CRC.
  - FSM state encodings IDLE/HDR/PLD/CRC.
  - LFSR_WIDTH=7.
- Sub-module ble_whiten_lfsr7 (load, advance, channel_number → lfsr[6] tap). Reusable by the TX path.

Test Plan:
- Channel 0, start, then 7 whitened zero bits → data_out = 0,0,0,0,0,0,1. This equals the whitening sequence, since input is 0.
- Reference-model round trip, channel 37, header 0x0240 (length 2), 2 payload bytes, 3 CRC bytes:
  - 56 valid outputs with regions 16×0, 16×1, 24×2.
  - payload_length=2.
  - data_out_last only on output 56.
  - Output equals the original plaintext.
- Length 0 frame → regions 16×0 then 24×2; last on output 40.
- data_in_valid toggling 1/0 every cycle across a frame → identical output bit sequence to the back-to-back case, every output delayed one cycle from its input.
- start asserted at payload bit 5 with data_in_valid=1 → that bit produces no output; new frame decodes correctly; no last pulse for the aborted frame.
- Macro defined, MAX_PAYLOAD_LEN=37, header length 38 → len_error pulse with header bit 15 output, busy→0, no further outputs. Macro undefined → frame completes normally.

Source files
------------

// File: rtl/ble_rx_pkg.sv
// Shared constants and encodings for the BLE RX de-whitening framer and the
// 7-bit whitening LFSR.
package ble_rx_pkg;

  localparam int HDR_BITS      = 16;
  localparam int CRC_BITS      = 24;
  localparam int LEN_LSB_POS   = 8;
  localparam int LFSR_WIDTH    = 7;
  localparam int BIT_CNT_WIDTH = 11;

  typedef enum logic [1:0] {
    REGION_HDR = 2'd0,
    REGION_PLD = 2'd1,
    REGION_CRC = 2'd2
  } region_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2,
    CRC  = 2'd3
  } state_e;

endpackage

// File: rtl/ble_whiten_lfsr7.sv
// x^7+x^4+1 BLE whitening LFSR: channel load, single-step advance, lfsr[6] tap.
// Shared between the TX whitener and the RX de-whitener.
module ble_whiten_lfsr7
  import ble_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [5:0] i_channel_number,
  input  logic       i_advance,
  output logic       o_tap
);

  logic [LFSR_WIDTH-1:0] r_lfsr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 7'b000_0001;
    end else if (i_load) begin
      // Channel bits land bit-reversed: lfsr[1]=ch[5] ... lfsr[6]=ch[0].
      r_lfsr <= {i_channel_number[0], i_channel_number[1], i_channel_number[2],
                 i_channel_number[3], i_channel_number[4], i_channel_number[5], 1'b1};
    end else if (i_advance) begin
      r_lfsr <= {r_lfsr[5:4], r_lfsr[3] ^ r_lfsr[6], r_lfsr[2:0], r_lfsr[6]};
    end
  end

  assign o_tap = r_lfsr[6];

endmodule

// File: rtl/ble_rx_dewhiten_framer.sv
// BLE RX de-whitener and frame tagger: header/payload/CRC region, last-bit flag.
// Optional payload length limit check under `DEWHITEN_LEN_CHECK_EN.
module ble_rx_dewhiten_framer
  import ble_rx_pkg::*;
#(
  parameter int unsigned CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int unsigned LEN_BIT_WIDTH            = 8,
  parameter int unsigned MAX_PAYLOAD_LEN          = 255
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                start,
  input  logic                                data_in,
  input  logic                                data_in_valid,
  output logic                                data_out,
  output logic                                data_out_valid,
  output logic                                data_out_last,
  output logic [1:0]                          bit_region,
  output logic [LEN_BIT_WIDTH-1:0]            payload_length,
  output logic                                busy,
  output logic                                len_error
);

  localparam logic [BIT_CNT_WIDTH-1:0] C_HDR_END = BIT_CNT_WIDTH'(HDR_BITS - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] C_CRC_END = BIT_CNT_WIDTH'(CRC_BITS - 1);
  localparam logic [BIT_CNT_WIDTH-1:0] C_LEN_LSB = BIT_CNT_WIDTH'(LEN_LSB_POS);

  state_e                     r_state, w_state_next;
  logic [BIT_CNT_WIDTH-1:0]   r_bit_cnt, w_bit_cnt_next, w_pld_end;
  logic [LEN_BIT_WIDTH-2:0]   r_len_shift;
  logic [LEN_BIT_WIDTH-1:0]   r_payload_length, w_len_next;
  region_e                    w_region;
  logic                       w_accept, w_tap, w_dw_bit, w_hdr_end, w_last, w_len_bad;
  logic                       r_data_out, r_data_out_valid, r_data_out_last, r_len_error;
  logic [1:0]                 r_bit_region;

  ble_whiten_lfsr7 u_lfsr (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_load           (start),
    .i_channel_number (channel_number[5:0]),
    .i_advance        (w_accept),
    .o_tap            (w_tap)
  );

  assign w_accept   = data_in_valid && !start && (r_state != IDLE);
  assign w_dw_bit   = w_tap ^ data_in;
  assign w_len_next = {w_dw_bit, r_len_shift};
  assign w_hdr_end  = w_accept && (r_state == HDR) && (r_bit_cnt == C_HDR_END);
  assign w_pld_end  = BIT_CNT_WIDTH'({r_payload_length, 3'b000}) - BIT_CNT_WIDTH'(1);

`ifdef DEWHITEN_LEN_CHECK_EN
  assign w_len_bad = 32'(w_len_next) > MAX_PAYLOAD_LEN;
`else
  logic w_unused_max_len;
  assign w_len_bad        = 1'b0;
  assign w_unused_max_len = |MAX_PAYLOAD_LEN;
`endif

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_region       = REGION_HDR;
    w_last         = 1'b0;
    unique case (r_state)
      PLD:     w_region = REGION_PLD;
      CRC:     w_region = REGION_CRC;
      default: w_region = REGION_HDR;
    endcase
    if (start) begin
      w_state_next   = HDR;
      w_bit_cnt_next = '0;
    end else if (w_accept) begin
      w_bit_cnt_next = r_bit_cnt + BIT_CNT_WIDTH'(1);
      unique case (r_state)
        HDR: if (r_bit_cnt == C_HDR_END) begin
          w_bit_cnt_next = '0;
          if (w_len_bad)            w_state_next = IDLE;
          else if (w_len_next == 0) w_state_next = CRC;
          else                      w_state_next = PLD;
        end
        PLD: if (r_bit_cnt == w_pld_end) begin
          w_bit_cnt_next = '0;
          w_state_next   = CRC;
        end
        CRC: if (r_bit_cnt == C_CRC_END) begin
          w_bit_cnt_next = '0;
          w_state_next   = IDLE;
          w_last         = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out       <= 1'b0;
      r_data_out_valid <= 1'b0;
      r_data_out_last  <= 1'b0;
      r_bit_region     <= 2'd0;
      r_len_error      <= 1'b0;
      r_len_shift      <= '0;
      r_payload_length <= '0;
    end else begin
      r_data_out_valid <= w_accept;
      r_data_out_last  <= w_last;
      r_len_error      <= w_hdr_end && w_len_bad;
      if (w_accept) begin
        r_data_out   <= w_dw_bit;
        r_bit_region <= w_region;
      end
      if (start) begin
        r_len_shift      <= '0;
        r_payload_length <= '0;
      end else if (w_accept && (r_state == HDR) && (r_bit_cnt >= C_LEN_LSB)) begin
        // Length is published only once complete, with the header's final bit.
        r_len_shift <= w_len_next[LEN_BIT_WIDTH-1:1];
        if (r_bit_cnt == C_HDR_END) r_payload_length <= w_len_next;
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign data_out_last  = r_data_out_last;
  assign bit_region     = r_bit_region;
  assign payload_length = r_payload_length;
  assign busy           = (r_state != IDLE);
  assign len_error      = r_len_error;

endmodule

// File: tb/tb_ble_rx_dewhiten_framer.sv
// Scoreboard bench for ble_rx_dewhiten_framer: directed frames are whitened by
// a bench-side LFSR model, expected plaintext is queued and checked by a monitor.
module tb_ble_rx_dewhiten_framer;

  typedef logic [7:0] bytes_q_t[$];
  typedef struct {
    logic       b;
    logic [1:0] region;
    logic       last;
    logic       lerr;
    int         exp_len;
    int         stamp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] channel_number = '0;
  logic       start = 1'b0;
  logic       data_in = 1'b0;
  logic       data_in_valid = 1'b0;
  logic       data_out, data_out_valid, data_out_last, busy, len_error;
  logic [1:0] bit_region;
  logic [7:0] payload_length;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [6:0] m_lfsr;

  ble_rx_dewhiten_framer #(
    .CHANNEL_NUMBER_BIT_WIDTH (6),
    .LEN_BIT_WIDTH            (8),
    .MAX_PAYLOAD_LEN          (37)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .channel_number (channel_number),
    .start          (start),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_last  (data_out_last),
    .bit_region     (bit_region),
    .payload_length (payload_length),
    .busy           (busy),
    .len_error      (len_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Whitening model: x^7+x^4+1, output taken from position 6.
  function automatic void model_load(input logic [5:0] ch);
    m_lfsr[0] = 1'b1;
    for (int k = 1; k <= 6; k++) m_lfsr[k] = ch[6-k];
  endfunction

  function automatic logic model_step();
    logic t;
    t = m_lfsr[6];
    m_lfsr = {m_lfsr[5:4], m_lfsr[3] ^ t, m_lfsr[2:0], t};
    return t;
  endfunction

  task automatic drive(input logic s, input logic [5:0] ch, input logic v, input logic d);
    @(posedge clk);
    #1;
    start = s; channel_number = ch; data_in_valid = v; data_in = d;
  endtask

  task automatic push_exp(input logic b, input logic [1:0] r, input logic l, input logic e,
                          input int len);
    exp_t x;
    x.b = b; x.region = r; x.last = l; x.lerr = e; x.exp_len = len; x.stamp = cyc;
    exp_q.push_back(x);
  endtask

  // Sends one frame; the start cycle always carries a valid bit that must be dropped.
  task automatic run_frame(input logic [5:0] ch, input logic [15:0] hdr, input bytes_q_t pl,
                           input logic [23:0] crc, input bit gaps, input int stop_after,
                           input bit expect_lerr);
    logic plain[$];
    int   n, len;
    logic w;
    logic [1:0] r;
    for (int i = 0; i < 16; i++) plain.push_back(hdr[i]);
    foreach (pl[k]) for (int j = 0; j < 8; j++) plain.push_back(pl[k][j]);
    for (int i = 0; i < 24; i++) plain.push_back(crc[i]);
    n   = plain.size();
    len = int'(hdr[15:8]);
    drive(1'b1, ch, 1'b1, 1'($urandom));
    model_load(ch);
    for (int i = 0; i < n; i++) begin
      if (stop_after >= 0 && i == stop_after) return;
      w = plain[i] ^ model_step();
      drive(1'b0, ch, 1'b1, w);
      r = (i < 16) ? 2'd0 : (i < 16 + len * 8) ? 2'd1 : 2'd2;
      if (!(expect_lerr && i > 15))
        push_exp(plain[i], r, (i == n - 1) && !expect_lerr, expect_lerr && (i == 15),
                 (i == 15) ? len : -1);
      if (gaps) drive(1'b0, ch, 1'b0, 1'($urandom));
    end
    drive(1'b0, ch, 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every valid output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_bit_region_last_lerr", {data_out, bit_region, data_out_last, len_error},
                {e.b, e.region, e.last, e.lerr});
          check("out_latency", cyc - e.stamp, 1);
          if (e.exp_len >= 0) check("payload_length_at_hdr15", payload_length, e.exp_len);
        end
      end else if (data_out_last || len_error) begin
        check("strobe_without_valid", {data_out_last, len_error}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bytes_q_t pl2, pl0, pl1, pl38;
    pl2  = '{8'hA5, 8'h3C};
    pl1  = '{8'h96};
    for (int i = 0; i < 38; i++) pl38.push_back(8'(i * 7 + 1));

    // Reset state
    #23;
    check("rst_outputs", {data_out, data_out_valid, data_out_last, bit_region,
                          busy, len_error}, 0);
    check("rst_payload_length", payload_length, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Bits presented in IDLE produce no output (the monitor flags any).
    drive(1'b0, 6'd0, 1'b1, 1'b1);
    drive(1'b0, 6'd0, 1'b1, 1'b0);

    // Channel 0 with zero input: output is the raw whitening sequence.
    drive(1'b1, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 6'd0, 1'b1, 1'b0);
      push_exp((i == 6) ? 1'b1 : 1'b0, 2'd0, 1'b0, 1'b0, -1);
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    wait_drain("drain_ch0_seq");
    check("busy_mid_header", busy, 1);

    // Channel 37 round trip, length 2, back to back (restarts the aborted frame above).
    run_frame(6'd37, 16'h0240, pl2, 24'hC3_5A_17, 1'b0, -1, 1'b0);
    wait_drain("drain_rt_ch37");
    check("rt_payload_length", payload_length, 2);
    check("rt_busy_after", busy, 0);

    // Zero-length payload: header then straight to CRC.
    run_frame(6'd12, 16'h0005, pl0, 24'h81_FE_42, 1'b0, -1, 1'b0);
    wait_drain("drain_len0");
    check("len0_payload_length", payload_length, 0);

    // Valid toggling every cycle: same plaintext, latency still one cycle.
    run_frame(6'd37, 16'h0240, pl2, 24'hC3_5A_17, 1'b1, -1, 1'b0);
    wait_drain("drain_gaps");
    check("gaps_busy_after", busy, 0);

    // Abort at payload bit 5 by a start carrying a valid bit, then a clean frame.
    run_frame(6'd37, 16'h0240, pl2, 24'hC3_5A_17, 1'b0, 21, 1'b0);
    run_frame(6'd8, 16'h0101, pl1, 24'h5A_A5_0F, 1'b0, -1, 1'b0);
    wait_drain("drain_abort");
    check("abort_payload_length", payload_length, 1);

    // Length 38 against a limit of 37.
`ifdef DEWHITEN_LEN_CHECK_EN
    run_frame(6'd21, 16'h2640, pl38, 24'h12_34_56, 1'b0, -1, 1'b1);
`else
    run_frame(6'd21, 16'h2640, pl38, 24'h12_34_56, 1'b0, -1, 1'b0);
`endif
    wait_drain("drain_len38");
    check("len38_busy_after", busy, 0);
    check("len38_payload_length", payload_length, 38);

    // Asynchronous reset mid-frame after the length is known.
    run_frame(6'd37, 16'h0240, pl2, 24'hC3_5A_17, 1'b0, 20, 1'b0);
    drive(1'b0, 6'd37, 1'b0, 1'b0);
    wait_drain("drain_pre_reset");
    check("pre_reset_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {data_out, data_out_valid, data_out_last, bit_region,
                                busy, len_error}, 0);
    check("mid_reset_payload_length", payload_length, 0);
    @(negedge clk) rst_n = 1'b1;

    // Normal frame after reset.
    run_frame(6'd5, 16'h0101, pl1, 24'hFF_00_FF, 1'b0, -1, 1'b0);
    wait_drain("drain_post_reset");
    check("post_reset_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
